// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: access-size encodings,
// byte-lane masks, FSM state encoding and small size helpers.
package mem_pkg;

    // Access size, same encoding as funct3[1:0]
    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_X = 2'b11;

    // Byte-lane masks for an access starting at lane 0
    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_BEAT0,
        ST_BEAT1,
        ST_RESP
    } state_t;

    function automatic logic [2:0] size_nbytes(input logic [1:0] size);
        case (size)
            SIZE_B:  return 3'd1;
            SIZE_H:  return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            SIZE_B:  return MASK_B;
            SIZE_H:  return MASK_H;
            default: return MASK_W;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bus between the core's load/store path and the data memory.
interface data_mem_responder_if;
    logic        reqValid;
    logic        reqReady;
    logic        reqWr;
    logic [1:0]  reqSize;
    logic        reqUext;
    logic [31:0] reqAddr;
    logic [31:0] reqWData;
    logic        respValid;
    logic [31:0] respRData;
    logic        respErr;

    modport master (
        output reqValid, reqWr, reqSize, reqUext, reqAddr, reqWData,
        input  reqReady, respValid, respRData, respErr
    );

    modport slave (
        input  reqValid, reqWr, reqSize, reqUext, reqAddr, reqWData,
        output reqReady, respValid, respRData, respErr
    );
endinterface

// File: rtl/sp_ram_be.sv
// Single-port synchronous RAM, 32-bit words with per-byte write enables.
// Read data is registered; contents are not reset.
module sp_ram_be #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 10
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    be,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Byte-lane write and registered read, both committed at the end of the beat
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: one byte/half/word access per handshake on a
// word-organised RAM. Accesses straddling a word boundary take two beats.
// Loads are sign/zero extended; errors are detected at acceptance and never
// touch the RAM.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 0
) (
    input logic                 clk,
    input logic                 rstN,
    data_mem_responder_if.slave bus
);

    localparam int          AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [30:0] DEPTH31 = 31'(DEPTH_WORDS);

    state_t      state;
    logic [3:0]  wcnt;
    logic        wr_q, uext_q, cross_q, err_q;
    logic [1:0]  size_q, off_q;
    logic [29:0] word0_q;
    logic [31:0] wdata_q, lo_q;
    logic        resp_valid_q, resp_err_q;
    logic [31:0] resp_rdata_q;

    // Acceptance decode. Second-word index is 31 bits wide so that word
    // 0x3FFFFFFF + 1 is seen as out of range rather than wrapping to 0.
    logic [29:0] word0_in;
    logic [30:0] word1_in;
    logic        cross_in, err_in;

    assign word0_in = bus.reqAddr[31:2];
    assign word1_in = {1'b0, word0_in} + 31'd1;
    assign cross_in = ({1'b0, bus.reqAddr[1:0]} + size_nbytes(bus.reqSize)) > 3'd4;
    assign err_in   = (bus.reqSize == SIZE_X)
                   || ({1'b0, word0_in} >= DEPTH31)
                   || (cross_in && (word1_in >= DEPTH31));

    // Store lanes: data and mask shifted into a two-word window
    logic [63:0] lane_data;
    logic [7:0]  lane_mask;

    assign lane_data = {32'b0, wdata_q} << {off_q, 3'b000};
    assign lane_mask = {4'b0, size_mask(size_q)} << off_q;

    // RAM port: BEAT1 addresses the following word and uses the high lanes
    logic          ram_en, ram_we, in_beat1;
    logic [AW-1:0] ram_addr;
    logic [3:0]    ram_be;
    logic [31:0]   ram_wdata, ram_rdata;

    assign in_beat1  = (state == ST_BEAT1);
    assign ram_en    = (state == ST_BEAT0) || in_beat1;
    assign ram_we    = ram_en && wr_q;
    assign ram_addr  = in_beat1 ? AW'(word0_q + 30'd1) : AW'(word0_q);
    assign ram_be    = in_beat1 ? lane_mask[7:4] : lane_mask[3:0];
    assign ram_wdata = in_beat1 ? lane_data[63:32] : lane_data[31:0];

    sp_ram_be #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_ram (
        .clk  (clk),
        .en   (ram_en),
        .we   (ram_we),
        .addr (ram_addr),
        .be   (ram_be),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

    // Load assembly: in RESP the RAM output holds the last beat's word; for a
    // crossing access the first word was parked in lo_q during BEAT1.
    logic [63:0] asm64;
    logic [31:0] shifted, load_res;

    assign asm64   = cross_q ? {ram_rdata, lo_q} : {32'b0, ram_rdata};
    assign shifted = 32'(asm64 >> {off_q, 3'b000});

    // Truncate to access size and extend
    always_comb begin
        load_res = shifted;
        case (size_q)
            SIZE_B:  load_res = {{24{~uext_q & shifted[7]}},  shifted[7:0]};
            SIZE_H:  load_res = {{16{~uext_q & shifted[15]}}, shifted[15:0]};
            default: load_res = shifted;
        endcase
    end

    // Control FSM with registered response outputs
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state        <= ST_IDLE;
            wcnt         <= '0;
            wr_q         <= 1'b0;
            uext_q       <= 1'b0;
            cross_q      <= 1'b0;
            err_q        <= 1'b0;
            size_q       <= SIZE_B;
            off_q        <= '0;
            word0_q      <= '0;
            wdata_q      <= '0;
            lo_q         <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.reqValid) begin
                        wr_q    <= bus.reqWr;
                        uext_q  <= bus.reqUext;
                        size_q  <= bus.reqSize;
                        off_q   <= bus.reqAddr[1:0];
                        word0_q <= word0_in;
                        wdata_q <= bus.reqWData;
                        cross_q <= cross_in;
                        err_q   <= err_in;
                        if (err_in) begin
                            state <= ST_RESP;
                        end else if (WAIT_STATES > 0) begin
                            wcnt  <= 4'(WAIT_STATES - 1);
                            state <= ST_WAIT;
                        end else begin
                            state <= ST_BEAT0;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wcnt == 4'd0) state <= ST_BEAT0;
                    else              wcnt  <= wcnt - 4'd1;
                end
                ST_BEAT0: state <= cross_q ? ST_BEAT1 : ST_RESP;
                ST_BEAT1: begin
                    lo_q  <= ram_rdata;
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= err_q;
                    resp_rdata_q <= (err_q || wr_q) ? 32'd0 : load_res;
                    state        <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.reqReady  = (state == ST_IDLE);
    assign bus.respValid = resp_valid_q;
    assign bus.respErr   = resp_err_q;
    assign bus.respRData = resp_rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: two responders (0 and 3 wait states). Stimulus pushes the
// hand-computed response into a per-DUT queue; monitors pop and compare data,
// error flag and accept-to-response latency whenever respValid is seen.
module tb_data_mem_responder;
    import mem_pkg::*;

    logic clk = 1'b0;
    logic rstN;
    always #5 clk = ~clk;

    logic        v0, v3, t_wr, t_uext;
    logic [1:0]  t_sz;
    logic [31:0] t_addr, t_wd;

    data_mem_responder_if b0();
    data_mem_responder_if b3();

    assign b0.reqValid = v0;     assign b3.reqValid = v3;
    assign b0.reqWr    = t_wr;   assign b3.reqWr    = t_wr;
    assign b0.reqSize  = t_sz;   assign b3.reqSize  = t_sz;
    assign b0.reqUext  = t_uext; assign b3.reqUext  = t_uext;
    assign b0.reqAddr  = t_addr; assign b3.reqAddr  = t_addr;
    assign b0.reqWData = t_wd;   assign b3.reqWData = t_wd;

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rstN(rstN), .bus(b0));
    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) dut3 (
        .clk(clk), .rstN(rstN), .bus(b3));

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          acc;
        int          tag;
    } exp_t;

    exp_t q0[$];
    exp_t q3[$];
    int   cyc = 0;
    int   total = 0;
    int   passed = 0;
    int   tag = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_resp(input string who, input exp_t e, input logic [31:0] rd,
                              input logic err);
        chk($sformatf("%s req%0d rdata", who, e.tag), rd, e.rd);
        chk($sformatf("%s req%0d err", who, e.tag), {31'b0, err}, {31'b0, e.err});
        chk($sformatf("%s req%0d latency", who, e.tag), 32'(cyc - e.acc - 1), 32'(e.lat));
    endtask

    // Monitor for the zero-wait-state responder
    always @(negedge clk) begin : mon0
        exp_t e;
        if (rstN === 1'b1 && b0.respValid === 1'b1) begin
            if (q0.size() == 0) begin
                total++;
                $display("FAIL dut0 unexpected response: got respValid=1 expected 0");
            end else begin
                e = q0.pop_front();
                check_resp("dut0", e, b0.respRData, b0.respErr);
            end
        end
    end

    // Monitor for the three-wait-state responder
    always @(negedge clk) begin : mon3
        exp_t e;
        if (rstN === 1'b1 && b3.respValid === 1'b1) begin
            if (q3.size() == 0) begin
                total++;
                $display("FAIL dut3 unexpected response: got respValid=1 expected 0");
            end else begin
                e = q3.pop_front();
                check_resp("dut3", e, b3.respRData, b3.respErr);
            end
        end
    end

    // Present a request (valid stays high on return) and record the expectation.
    // exp_busy >= 0 also checks how many cycles reqReady stayed low first.
    task automatic do_req(input bit sel, input logic wr, input logic [1:0] sz,
                          input logic uext, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err,
                          input int exp_lat, input int exp_busy);
        int   busy;
        exp_t e;
        @(negedge clk);
        t_wr = wr; t_sz = sz; t_uext = uext; t_addr = addr; t_wd = wd;
        if (sel) v3 = 1'b1; else v0 = 1'b1;
        busy = 0;
        while (!(sel ? b3.reqReady : b0.reqReady) && busy < 60) begin
            @(negedge clk);
            busy++;
        end
        if (busy >= 60) begin
            total++;
            $display("FAIL req%0d accept timeout: reqReady stayed 0, expected 1", tag);
            v0 = 1'b0; v3 = 1'b0;
            tag++;
            return;
        end
        if (exp_busy >= 0)
            chk($sformatf("req%0d reqReady low cycles", tag), 32'(busy), 32'(exp_busy));
        e = '{rd: exp_rd, err: exp_err, lat: exp_lat, acc: cyc, tag: tag};
        if (sel) q3.push_back(e); else q0.push_back(e);
        tag++;
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        v0 = 1'b0; v3 = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() != 0 || q3.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (q0.size() != 0 || q3.size() != 0) begin
            total++;
            $display("FAIL drain: got %0d responses pending expected 0", q0.size() + q3.size());
        end
    endtask

    task automatic chk_reset_outs(input string who, input bit sel);
        chk({who, " reqReady"},  {31'b0, sel ? b3.reqReady  : b0.reqReady},  32'd1);
        chk({who, " respValid"}, {31'b0, sel ? b3.respValid : b0.respValid}, 32'd0);
        chk({who, " respErr"},   {31'b0, sel ? b3.respErr   : b0.respErr},   32'd0);
        chk({who, " respRData"}, sel ? b3.respRData : b0.respRData,          32'd0);
    endtask

    initial begin
        rstN = 1'b0; v0 = 1'b0; v3 = 1'b0;
        t_wr = 1'b0; t_sz = SIZE_B; t_uext = 1'b0; t_addr = '0; t_wd = '0;
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        chk_reset_outs("dut0 reset", 1'b0);
        chk_reset_outs("dut3 reset", 1'b1);

        // Aligned word store/load and byte extension
        do_req(0, 1, SIZE_W, 0, 32'h10, 32'hDEADBEEF, 32'h0,        0, 2, -1);
        do_req(0, 0, SIZE_W, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0, 2, -1);
        do_req(0, 0, SIZE_B, 0, 32'h13, 32'h0,        32'hFFFFFFDE, 0, 2, -1);
        do_req(0, 0, SIZE_B, 1, 32'h13, 32'h0,        32'h000000DE, 0, 2, -1);

        // Crossing half store between known neighbours
        do_req(0, 1, SIZE_W, 0, 32'h1C, 32'h01020304, 32'h0,        0, 2, -1);
        do_req(0, 1, SIZE_W, 0, 32'h20, 32'h05060708, 32'h0,        0, 2, -1);
        do_req(0, 1, SIZE_H, 0, 32'h1F, 32'h0000A55A, 32'h0,        0, 3, -1);
        do_req(0, 0, SIZE_H, 1, 32'h1F, 32'h0,        32'h0000A55A, 0, 3, -1);
        do_req(0, 0, SIZE_H, 0, 32'h1F, 32'h0,        32'hFFFFA55A, 0, 3, -1);
        do_req(0, 0, SIZE_W, 0, 32'h1C, 32'h0,        32'h5A020304, 0, 2, -1);
        do_req(0, 0, SIZE_W, 0, 32'h20, 32'h0,        32'h050607A5, 0, 2, -1);

        // Errors: illegal size, word out of range, second word out of range
        do_req(0, 1, SIZE_W, 0, 32'hFFC, 32'hCAFEF00D, 32'h0,        0, 2, -1);
        do_req(0, 1, SIZE_X, 0, 32'h10,  32'h0,        32'h0,        1, 1, -1);
        do_req(0, 0, SIZE_W, 0, 32'h10,  32'h0,        32'hDEADBEEF, 0, 2, -1);
        do_req(0, 0, SIZE_W, 0, 32'h1000, 32'h0,       32'h0,        1, 1, -1);
        do_req(0, 1, SIZE_W, 0, 32'hFFE, 32'h11111111, 32'h0,        1, 1, -1);
        do_req(0, 0, SIZE_W, 0, 32'hFFC, 32'h0,        32'hCAFEF00D, 0, 2, -1);
        idle();

        // Wait states, with the second request held while busy
        do_req(1, 1, SIZE_W, 0, 32'h0, 32'h12345678, 32'h0,        0, 5, -1);
        do_req(1, 0, SIZE_W, 0, 32'h0, 32'h0,        32'h12345678, 0, 5, 5);
        idle();

        // Reset during BEAT1 of a crossing word store
        do_req(0, 1, SIZE_W, 0, 32'h40, 32'h11223344, 32'h0,        0, 2, -1);
        do_req(0, 1, SIZE_W, 0, 32'h44, 32'h55667788, 32'h0,        0, 2, -1);
        do_req(0, 0, SIZE_W, 0, 32'h40, 32'h0,        32'h11223344, 0, 2, -1);
        idle();
        drain();
        @(negedge clk);
        t_wr = 1'b1; t_sz = SIZE_W; t_uext = 1'b0; t_addr = 32'h42; t_wd = 32'hAABBCCDD;
        v0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v0 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort pre reqReady",  {31'b0, b0.reqReady}, 32'd0);
        chk("abort pre respRData", b0.respRData, 32'h11223344);
        rstN = 1'b0;
        #1;
        chk_reset_outs("dut0 abort", 1'b0);
        @(negedge clk);
        rstN = 1'b1;
        do_req(0, 0, SIZE_W, 0, 32'h40, 32'h0, 32'hCCDD3344, 0, 2, -1);
        do_req(0, 0, SIZE_W, 0, 32'h44, 32'h0, 32'h55667788, 0, 2, -1);
        idle();
        drain();
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the core's load/store path: accepts one byte/half/word access per handshake, performs byte-lane writes or sign/zero-extended reads on an internal word-organised RAM, and returns a single-cycle response. Misaligned accesses that straddle a word boundary are split into two RAM beats internally. The block sits between the datapath's memory control signals (`memWr`, size, `uext`, address) and data storage. It is the data-memory counterpart of the instruction decoder.

## Interface
- `DEPTH_WORDS`, 1024: RAM depth in 32-bit words. Valid byte addresses are 0 .. 4*DEPTH_WORDS-1.
- `WAIT_STATES`, 0: extra idle cycles inserted after acceptance, before the first beat (0..15).
- `clk` in 1: single clock, rising edge.
- `rstN` in 1: asynchronous, active-low reset.
- `reqValid` in 1: request present.
- `reqReady` out 1: block can accept a request. High only in IDLE.
- `reqWr` in 1: 1 = store, 0 = load.
- `reqSize` in 2: 00 byte, 01 half, 10 word, 11 illegal. Same encoding as funct3[1:0].
- `reqUext` in 1: load zero-extend (1) or sign-extend (0). Ignored for word and for stores.
- `reqAddr` in 32: byte address.
- `reqWData` in 32: store data, right-justified.
- `respValid` out 1: one-cycle pulse marking completion.
- `respRData` out 32: load result. 0 for stores and errors.
- `respErr` out 1: request rejected (size 11, or any touched word ≥ DEPTH_WORDS).

## Operation
- Accept on a rising edge with `reqValid && reqReady`. Latch all request fields, then leave IDLE.
- FSM states and transitions:
  - IDLE → WAIT (if WAIT_STATES > 0) or BEAT0.
  - WAIT: counts down WAIT_STATES cycles, then → BEAT0.
  - BEAT0: accesses word `addr[31:2]`. → BEAT1 if the access crosses a word boundary, else → RESP.
  - BEAT1: accesses word `addr[31:2]+1`, then → RESP.
  - RESP: asserts `respValid`, then → IDLE.
- Crossing condition: `addr[1:0] + nbytes > 4`, where nbytes is 1/2/4.
- Error check at acceptance. On error, go straight to RESP with `respErr=1`, `respRData=0`. No RAM write occurs on either word. The second-word index is computed in 31 bits, so it does not wrap at 0xFFFFFFFC: word 2^30 is out of range.
- Store path:
  - 64-bit lane data = `reqWData << 8*addr[1:0]`.
  - 8-bit byte mask = (0001/0011/1111 by size) `<< addr[1:0]`.
  - BEAT0 writes the low 32 bits under mask[3:0]. BEAT1 writes the high 32 bits under mask[7:4].
- Load path:
  - BEAT0 and BEAT1 capture words into a 64-bit assembly register. The high half is 0 if there is no BEAT1.
  - Result = assembly `>> 8*addr[1:0]`, truncated to size, then sign- or zero-extended per `reqUext`.
- `reqValid` while not in IDLE is ignored; the requester holds it until `reqReady`.

## Timing
- Reset values: state IDLE, `reqReady=1`, `respValid=0`, `respRData=0`, `respErr=0`, wait counter 0. RAM contents are not reset.
- Latency from the accept edge to the cycle with `respValid` high:
  - Aligned access: WAIT_STATES + 2 cycles.
  - Crossing access: WAIT_STATES + 3 cycles.
  - Error: 1 cycle.
- `reqReady` drops the cycle after acceptance and returns in the cycle after RESP.
- Maximum throughput: one aligned access per 3 cycles (WAIT_STATES = 0).
- `respRData` and `respErr` hold their value until the next RESP.
- RAM is synchronous: read data is registered at the end of the beat, and writes commit at the end of the beat.
- Reset asserted mid-operation aborts immediately to IDLE with no response. A crossing store aborted after BEAT0 leaves word0 written and word1 unchanged; this is defined, not atomic.

## Structure
- Shared package `mem_pkg`:
  - size encodings `SIZE_B/H/W`.
  - FSM state enum.
  - byte-mask constants.
- Sub-module `sp_ram_be`: single-port, synchronous, 32-bit wide, 4-bit byte-enable RAM, parameterised by DEPTH_WORDS.
- Lane alignment, extension and the FSM live in `data_mem_responder`.

## Test plan
- Word store `0xDEADBEEF` to 0x10, then word load 0x10 → `respRData=0xDEADBEEF`, `respErr=0`, `respValid` exactly 2 cycles after accept.
- Byte load at 0x13 of that word:
  - `reqUext=0` → 0xFFFFFFDE.
  - `reqUext=1` → 0x000000DE.
- Half store `0xA55A` at 0x1F (crossing), then half load 0x1F → 0x0000A55A with `reqUext=1`. Word 0x1C byte3 = 0x5A, word 0x20 byte0 = 0xA5; other bytes unchanged. Latency 3 cycles.
- Illegal and out-of-range requests, each → `respErr=1`, `respRData=0`, 1-cycle latency, RAM unchanged:
  - `reqSize=11`.
  - Word load at 4*DEPTH_WORDS.
  - Word store at 4*DEPTH_WORDS-2 (second word out of range).
- WAIT_STATES=3, aligned load → `respValid` 5 cycles after accept; `reqReady` low throughout; a held `reqValid` is accepted on the cycle `reqReady` returns.
- Assert `rstN` low during BEAT1 of a crossing store → outputs return to reset values asynchronously, no `respValid`; the next request is accepted normally.
